// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: drives rows one at a time, debounces whole-frame snapshots and
// emits one encoded key code with a single-cycle strobe per press/release cycle.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] Code_1,
  output logic       Valid_1,
  output logic       key_held,
  output logic       multi_err
);

  localparam int unsigned DivW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [7:0]      DebMax = 8'(DEBOUNCE);
  localparam bit              DebOne = (DEBOUNCE <= 1);

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

  logic [2:0]      col_sync1_q, col_sync1_d, col_sync2_q, col_sync2_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_q, row_d;
  logic [11:0]     snap_q, snap_d, cand_q, cand_d;
  logic            frame_done_q, frame_done_d;
  state_e          state_q, state_d;
  logic [7:0]      deb_cnt_q, deb_cnt_d, rel_cnt_q, rel_cnt_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d, held_q, held_d, multi_q, multi_d;

  logic sample, snap_empty, snap_single, snap_multi;

  // Snapshot bit 3r+c maps to row r, column c in layout order.
  function automatic logic [3:0] encode(input logic [11:0] k);
    logic [3:0] c;
    c = 4'h0;
    case (k)
      12'h001: c = 4'h1;
      12'h002: c = 4'h2;
      12'h004: c = 4'h3;
      12'h008: c = 4'h4;
      12'h010: c = 4'h5;
      12'h020: c = 4'h6;
      12'h040: c = 4'h7;
      12'h080: c = 4'h8;
      12'h100: c = 4'h9;
      12'h200: c = 4'hA;
      12'h400: c = 4'h0;
      12'h800: c = 4'hB;
      default: c = 4'h0;
    endcase
    return c;
  endfunction

  always_comb begin
    col_sync1_d  = col_in;
    col_sync2_d  = col_sync1_q;
    sample       = (div_q == DivMax);
    div_d        = sample ? '0 : div_q + 1'b1;
    row_d        = sample ? row_q + 2'd1 : row_q;
    snap_d       = snap_q;
    if (sample) snap_d[3*int'(row_q) +: 3] = ~col_sync2_q;
    frame_done_d = sample && (row_q == 2'd3);
  end

  assign row_out = ~(4'b0001 << row_q);

  always_comb begin
    snap_empty  = (snap_q == 12'h000);
    snap_single = !snap_empty && ((snap_q & (snap_q - 12'd1)) == 12'h000);
    snap_multi  = !snap_empty && !snap_single;
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    multi_d   = multi_q;
    if (frame_done_q) begin
      multi_d = snap_multi;
      unique case (state_q)
        StIdle: begin
          if (snap_single) begin
            cand_d = snap_q;
            if (DebOne) begin
              code_d    = encode(snap_q);
              valid_d   = 1'b1;
              held_d    = 1'b1;
              deb_cnt_d = DebMax;
              state_d   = StPressed;
            end else begin
              deb_cnt_d = 8'd1;
              state_d   = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (snap_q == cand_q) begin
            deb_cnt_d = deb_cnt_q + 8'd1;
            if ({1'b0, deb_cnt_q} + 9'd1 >= {1'b0, DebMax}) begin
              deb_cnt_d = DebMax;
              code_d    = encode(cand_q);
              valid_d   = 1'b1;
              held_d    = 1'b1;
              state_d   = StPressed;
            end
          end else begin
            deb_cnt_d = 8'd0;
            state_d   = StIdle;
          end
        end
        StPressed: begin
          // A second key while one is held is ignored until everything opens.
          if (snap_empty) begin
            if (DebOne) begin
              held_d    = 1'b0;
              deb_cnt_d = 8'd0;
              rel_cnt_d = 8'd0;
              state_d   = StIdle;
            end else begin
              rel_cnt_d = 8'd1;
              state_d   = StRelease;
            end
          end
        end
        StRelease: begin
          if (snap_empty) begin
            rel_cnt_d = rel_cnt_q + 8'd1;
            if ({1'b0, rel_cnt_q} + 9'd1 >= {1'b0, DebMax}) begin
              held_d    = 1'b0;
              deb_cnt_d = 8'd0;
              rel_cnt_d = 8'd0;
              state_d   = StIdle;
            end
          end else begin
            rel_cnt_d = 8'd0;
            state_d   = StPressed;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_1) begin
    if (reset_1) begin
      col_sync1_q  <= 3'b111;
      col_sync2_q  <= 3'b111;
      div_q        <= '0;
      row_q        <= 2'd0;
      snap_q       <= 12'h000;
      frame_done_q <= 1'b0;
      state_q      <= StIdle;
      cand_q       <= 12'h000;
      deb_cnt_q    <= 8'd0;
      rel_cnt_q    <= 8'd0;
      code_q       <= 4'h0;
      valid_q      <= 1'b0;
      held_q       <= 1'b0;
      multi_q      <= 1'b0;
    end else begin
      col_sync1_q  <= col_sync1_d;
      col_sync2_q  <= col_sync2_d;
      div_q        <= div_d;
      row_q        <= row_d;
      snap_q       <= snap_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      deb_cnt_q    <= deb_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      held_q       <= held_d;
      multi_q      <= multi_d;
    end
  end

  assign Code_1    = code_q;
  assign Valid_1   = valid_q;
  assign key_held  = held_q;
  assign multi_err = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad pulls columns low for closed keys
// in the active row; strobes and codes are logged by a monitor and checked against constants.
module tb_keypad_scanner;

  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned Debounce = 3;
  localparam int          Frame    = 4 * ScanDiv;

  logic       clk     = 1'b0;
  logic       reset_1 = 1'b1;
  logic [2:0] col_in;
  logic [3:0] row_out;
  logic [3:0] Code_1;
  logic       Valid_1;
  logic       key_held;
  logic       multi_err;

  logic [11:0] keys = 12'h000;
  logic [3:0]  codes[$];
  logic [3:0]  sweep_exp[12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                                 4'hA, 4'h0, 4'hB};
  int checks    = 0;
  int errors    = 0;
  int strobes   = 0;
  int bad_row   = 0;
  int bad_multi = 0;

  always #5 clk = ~clk;

  always_comb begin
    col_in = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_out[r] && keys[3*r+c]) col_in[c] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV (ScanDiv),
    .DEBOUNCE (Debounce)
  ) dut (
    .clk       (clk),
    .reset_1   (reset_1),
    .col_in    (col_in),
    .row_out   (row_out),
    .Code_1    (Code_1),
    .Valid_1   (Valid_1),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  always @(negedge clk) begin
    if (Valid_1) begin
      strobes++;
      codes.push_back(Code_1);
      if (multi_err) bad_multi++;
    end
    if ($countones(~row_out) != 1) bad_row++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * Frame) @(negedge clk);
  endtask

  initial begin
    int  n;
    bit  found;

    // Reset state, with '5' already closed so frame alignment is known.
    keys = 12'h010;
    repeat (3) @(negedge clk);
    check("rst_row_out", row_out, 4'b1110);
    check("rst_code", Code_1, 4'h0);
    check("rst_valid", Valid_1, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_multi", multi_err, 1'b0);

    // Test 1: '5' held; accept one clk after the third full-frame frame_done.
    reset_1 = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (Valid_1) found = 1'b1;
    end
    check("t1_latency", n, 49);
    frames(19);
    check("t1_strobes", strobes, 1);
    check("t1_code", Code_1, 4'h5);
    check("t1_held", key_held, 1'b1);
    keys = 12'h000;
    frames(1);
    check("t1_held_rel1", key_held, 1'b1);
    frames(5);
    check("t1_held_rel", key_held, 1'b0);
    check("t1_strobes_end", strobes, 1);

    // Test 2: '#' then '*'.
    keys = 12'h800; frames(6);
    keys = 12'h000; frames(6);
    keys = 12'h200; frames(6);
    keys = 12'h000; frames(6);
    check("t2_strobes", strobes, 3);
    check("t2_code_hash", codes[1], 4'hB);
    check("t2_code_star", codes[2], 4'hA);
    check("t2_code_hold", Code_1, 4'hA);

    // Test 3: bouncing '7' never reaches three matching frames.
    repeat (5) begin
      keys = 12'h040; frames(2);
      keys = 12'h000; frames(1);
    end
    frames(2);
    check("t3_strobes", strobes, 3);
    check("t3_code", Code_1, 4'hA);
    check("t3_held", key_held, 1'b0);

    // Test 4: '1'+'9' together, then '9' released.
    keys = 12'h101; frames(3);
    check("t4_multi_early", multi_err, 1'b1);
    frames(7);
    check("t4_multi_late", multi_err, 1'b1);
    check("t4_no_strobe", strobes, 3);
    keys = 12'h001; frames(2);
    check("t4_multi_clear", multi_err, 1'b0);
    check("t4_no_strobe_yet", strobes, 3);
    frames(3);
    check("t4_strobes", strobes, 4);
    check("t4_code", codes[3], 4'h1);
    keys = 12'h000; frames(6);

    // Test 5: reset in the middle of debouncing '0'.
    keys = 12'h400; frames(2);
    check("t5_pre_strobes", strobes, 4);
    @(negedge clk);
    reset_1 = 1'b1;
    #1;
    check("t5_rst_row", row_out, 4'b1110);
    check("t5_rst_code", Code_1, 4'h0);
    check("t5_rst_valid", Valid_1, 1'b0);
    check("t5_rst_held", key_held, 1'b0);
    check("t5_rst_multi", multi_err, 1'b0);
    repeat (2) @(negedge clk);
    reset_1 = 1'b0;
    frames(5);
    check("t5_strobes", strobes, 5);
    check("t5_code", codes[4], 4'h0);
    check("t5_held", key_held, 1'b1);
    keys = 12'h000; frames(6);

    // Test 6: sweep all keys in layout order.
    for (int i = 0; i < 12; i++) begin
      keys = 12'h001 << i; frames(5);
      keys = 12'h000;      frames(5);
    end
    check("t6_strobes", strobes, 17);
    for (int i = 0; i < 12; i++) check($sformatf("t6_code_%0d", i), codes[5+i], sweep_exp[i]);

    check("row_one_hot", bad_row, 0);
    check("valid_with_multi", bad_multi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
